// File: rtl/shared_pkg.sv
// Shared APB widths, UART register map and the APB requester state type.
package shared_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] UART_TX_DATA_ADDR = 16'h4000;
    localparam logic [ADDR_WIDTH-1:0] UART_RX_DATA_ADDR = 16'h4008;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_uart_master.sv
// APB4 requester for the UART segment: turns valid/ready commands into
// SETUP/ACCESS transfers and returns data, slave error or timeout on a strobe.
//
// state  | meaning
// IDLE   | ready for a command, bus outputs hold the last transfer
// SETUP  | PSELx=1, PENABLE=0, one cycle
// ACCESS | PSELx=1, PENABLE=1, wait for PREADY or timeout
module apb_uart_master
    import shared_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_strb,
    input  logic [2:0]            req_prot,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [2:0]            PPROT,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [3:0]            PSTRB,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    apb_state_e            r_state;
    apb_state_e            w_next;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [2:0]            r_pprot;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [3:0]            r_pstrb;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic                  w_hs;
    logic                  w_done;
    logic                  w_timeout;

    assign w_hs      = req_valid && (r_state == IDLE);
    assign w_done    = (r_state == ACCESS) && PREADY;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == ACCESS) && !PREADY
                       && (r_wait_cnt == CNT_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        PSELx     = 1'b0;
        PENABLE   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_hs) w_next = SETUP;
            end
            SETUP: begin
                PSELx  = 1'b1;
                w_next = ACCESS;
            end
            ACCESS: begin
                PSELx   = 1'b1;
                PENABLE = 1'b1;
                if (w_done || w_timeout) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Counter only advances on PREADY-low ACCESS cycles and never wraps.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wait_cnt <= '0;
        end else if (w_hs) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ACCESS) && !PREADY && (r_wait_cnt != CNT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_paddr  <= '0;
            r_pprot  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else if (w_hs) begin
            r_paddr  <= req_addr;
            r_pprot  <= req_prot;
            r_pwrite <= req_write;
            r_pwdata <= req_wdata;
            r_pstrb  <= req_write ? req_strb : 4'b0000;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else if (w_done) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
            r_rsp_err     <= PSLVERR;
            r_rsp_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
        end else begin
            r_rsp_valid   <= 1'b0;
        end
    end

    assign PADDR       = r_paddr;
    assign PPROT       = r_pprot;
    assign PWRITE      = r_pwrite;
    assign PWDATA      = r_pwdata;
    assign PSTRB       = r_pstrb;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_uart_master.sv
// Self-checking bench for apb_uart_master: directed cases plus randomized
// transfers checked cycle by cycle against a transaction-level expectation.
module tb_apb_uart_master;
    import shared_pkg::*;

    localparam int TO = 16;

    logic                  PCLK = 1'b0;
    logic                  PRESETn = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  req_write = 1'b0;
    logic [ADDR_WIDTH-1:0] req_addr = '0;
    logic [DATA_WIDTH-1:0] req_wdata = '0;
    logic [3:0]            req_strb = '0;
    logic [2:0]            req_prot = '0;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [2:0]            PPROT;
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [3:0]            PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA = '0;
    logic                  PREADY = 1'b0;
    logic                  PSLVERR = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic        last_to = 1'b0;

    apb_uart_master #(.TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PPROT(PPROT), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"}, PSELx, 1'b0);
        chk({tag, "_penable"}, PENABLE, 1'b0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_paddr"}, PADDR, 32'h0);
        chk({tag, "_pwdata"}, PWDATA, 32'h0);
        chk({tag, "_pstrb"}, PSTRB, 32'h0);
        chk({tag, "_pprot"}, PPROT, 32'h0);
        chk({tag, "_pwrite"}, PWRITE, 1'b0);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_err"}, rsp_err, 1'b0);
        chk({tag, "_timeout"}, rsp_timeout, 1'b0);
    endtask

    // Caller is at a negedge; each iteration checks one IDLE cycle.
    task automatic idle_cycles(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            PREADY = 1'(($urandom));
            PSLVERR = 1'($urandom);
            PRDATA = $urandom;
            @(negedge PCLK);
            chk("idle_psel", PSELx, 1'b0);
            chk("idle_rsp_valid", rsp_valid, 1'b0);
            chk("idle_rdata_hold", rsp_rdata, last_rdata);
            chk("idle_err_hold", rsp_err, last_err);
            chk("idle_to_hold", rsp_timeout, last_to);
            chk("idle_ready", req_ready, 1'b1);
        end
    endtask

    // One transfer, starting at a negedge with the DUT idle; returns at the
    // negedge of the response cycle. waits >= TO means the slave never responds.
    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic [2:0] prot, input int waits,
                        input logic [31:0] sd, input logic serr, input bit hold_valid);
        logic        to;
        int          n;
        logic [3:0]  es;
        logic [31:0] er;
        to = (waits >= TO);
        n  = to ? TO : waits + 1;
        es = wr ? strb : 4'b0000;
        er = (to || wr) ? 32'h0 : sd;

        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_wdata = wd; req_strb = strb; req_prot = prot;
        chk("hs_ready", req_ready, 1'b1);
        @(posedge PCLK);
        @(negedge PCLK);
        if (!hold_valid) req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = 16'($urandom);
        req_wdata = $urandom; req_strb = 4'($urandom); req_prot = 3'($urandom);
        chk("setup_psel", PSELx, 1'b1);
        chk("setup_penable", PENABLE, 1'b0);
        chk("setup_ready", req_ready, 1'b0);
        chk("setup_rsp_valid", rsp_valid, 1'b0);
        chk("setup_paddr", PADDR, addr);
        chk("setup_pwrite", PWRITE, wr);
        chk("setup_pwdata", PWDATA, wd);
        chk("setup_pstrb", PSTRB, es);
        chk("setup_pprot", PPROT, prot);
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            PREADY  = (!to && i == waits);
            PRDATA  = PREADY ? sd : $urandom;
            PSLVERR = PREADY ? serr : 1'($urandom);
            chk("acc_psel", PSELx, 1'b1);
            chk("acc_penable", PENABLE, 1'b1);
            chk("acc_ready", req_ready, 1'b0);
            chk("acc_rsp_valid", rsp_valid, 1'b0);
            chk("acc_paddr", PADDR, addr);
            chk("acc_pwdata", PWDATA, wd);
            chk("acc_pstrb", PSTRB, es);
        end
        @(negedge PCLK);
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_rdata", rsp_rdata, er);
        chk("rsp_err", rsp_err, to | serr);
        chk("rsp_timeout", rsp_timeout, to);
        chk("rsp_psel", PSELx, 1'b0);
        chk("rsp_penable", PENABLE, 1'b0);
        chk("rsp_ready", req_ready, 1'b1);
        chk("rsp_paddr_hold", PADDR, addr);
        chk("rsp_pstrb_hold", PSTRB, es);
        last_rdata = er; last_err = to | serr; last_to = to;
    endtask

    initial begin
        int w;
        bit hold;
        int gap;
        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge PCLK);
        chk_all_zero("reset_hold");
        PRESETn = 1'b1;
        #1;
        chk("post_reset_ready", req_ready, 1'b1);
        chk_all_zero("post_reset");
        idle_cycles(2);

        xfer(1'b1, UART_TX_DATA_ADDR, 32'hDEADBEEF, 4'b1111, 3'd0, 0, 32'h0, 1'b0, 1'b0);
        idle_cycles(2);
        xfer(1'b0, UART_RX_DATA_ADDR, 32'h12345678, 4'b1111, 3'd2, 3, 32'h000000EF, 1'b0, 1'b0);
        idle_cycles(1);
        xfer(1'b1, 16'h4001, 32'h55AA55AA, 4'b1111, 3'd1, 0, 32'h0, 1'b1, 1'b0);
        idle_cycles(1);
        xfer(1'b0, UART_RX_DATA_ADDR, 32'h0, 4'b1111, 3'd0, TO, 32'hFFFFFFFF, 1'b0, 1'b0);
        idle_cycles(2);
        xfer(1'b0, UART_RX_DATA_ADDR, 32'h0, 4'b1111, 3'd0, TO - 1, 32'hCAFEF00D, 1'b0, 1'b0);
        idle_cycles(1);

        xfer(1'b1, UART_TX_DATA_ADDR, 32'hDEADBEEF, 4'b1111, 3'd0, 0, 32'h0, 1'b0, 1'b1);
        xfer(1'b1, UART_TX_DATA_ADDR, 32'hAAAAAAAA, 4'b1111, 3'd0, 0, 32'h0, 1'b0, 1'b1);
        xfer(1'b1, UART_TX_DATA_ADDR, 32'hDEADBE1D, 4'b1110, 3'd0, 0, 32'h0, 1'b0, 1'b0);
        idle_cycles(1);

        // Reset during ACCESS: everything drops at once, no response follows.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h4000;
        req_wdata = 32'h0BADF00D; req_strb = 4'hF; req_prot = 3'd5;
        PREADY = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("pre_rst_penable", PENABLE, 1'b1);
        #2 PRESETn = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge PCLK);
        PRESETn = 1'b1;
        last_rdata = '0; last_err = 1'b0; last_to = 1'b0;
        xfer(1'b0, UART_RX_DATA_ADDR, 32'h0, 4'b1111, 3'd3, 1, 32'hA5A5A5A5, 1'b0, 1'b0);
        idle_cycles(1);

        for (int k = 0; k < 150; k++) begin
            w    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 1, TO + 3))
                                               : int'($urandom_range(0, 4));
            gap  = int'($urandom_range(0, 2));
            hold = (gap == 0);
            xfer(1'($urandom), 16'($urandom), $urandom, 4'($urandom), 3'($urandom),
                 w, $urandom, 1'($urandom), hold);
            if (gap != 0) idle_cycles(gap);
        end
        idle_cycles(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_uart_master.md
# apb_uart_master

APB4 requester that sits directly upstream of the UART APB wrapper and turns a simple valid/ready command port into legal two-phase APB transfers. A host-side controller issues single read or write requests. The block drives SETUP and ACCESS phases, waits for PREADY, and returns read data, slave error or timeout on a one-cycle response strobe. It is the only APB master on the UART segment and drives a single PSELx.

## Interface
- ADDR_WIDTH, 16, APB address width (from shared_pkg).
- DATA_WIDTH, 32, APB data width (from shared_pkg).
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout.

Clock/reset: one clock; reset is asynchronous and active-low.
- PCLK  in  1  clock.
- PRESETn  in  1  async active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid&&req_ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  target address.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  4  write byte strobes.
- req_prot  in  3  PPROT value.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  DATA_WIDTH  captured PRDATA (reads); 0 for writes.
- rsp_err  out  1  PSLVERR seen or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PADDR  out  ADDR_WIDTH  APB address.
- PPROT  out  3  APB protection.
- PSELx  out  1  slave select.
- PENABLE  out  1  access phase.
- PWRITE  out  1  direction.
- PWDATA  out  DATA_WIDTH  write data.
- PSTRB  out  4  byte strobes.
- PRDATA  in  DATA_WIDTH  read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error, sampled only with PREADY in ACCESS.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: req_ready=1. On handshake, register all req_* fields and go to SETUP.
  - SETUP: PSELx=1, PENABLE=0. Unconditionally go to ACCESS.
  - ACCESS: PSELx=1, PENABLE=1.
    - PREADY=1: capture PRDATA (reads only) and PSLVERR, go to IDLE, assert rsp_valid next cycle.
    - PREADY=0: increment wait counter.
    - Counter reaches TIMEOUT_CYCLES (nonzero): abort, go to IDLE, rsp_err=rsp_timeout=1, rsp_rdata=0.
- req_ready=0 in SETUP and ACCESS; no queuing.
- PADDR, PPROT, PWRITE, PWDATA and PSTRB are stable from SETUP through the end of ACCESS. They hold their last values in IDLE.
- Reads drive PSTRB=4'b0000 (APB4 rule) regardless of req_strb.
- Wait counter is $clog2(TIMEOUT_CYCLES+1) bits and clears on entry to SETUP. It never wraps; it saturates at the abort compare.
- Addresses and strobes pass through unchecked. Misalignment and protection errors are the slave's job and return via PSLVERR.

## Timing
- Reset values: state IDLE, req_ready=1 (once PRESETn high), every other output 0 (PADDR, PWDATA, PSTRB, PPROT, rsp_rdata included).
- Request handshake in cycle T: SETUP at T+1, ACCESS at T+2.
- PREADY high in ACCESS cycle T+2+w: rsp_valid at T+3+w. State is IDLE in the same cycle, so the next request can be accepted then.
- Back-to-back throughput with zero wait states: one transfer per 3 cycles.
- Timeout with TIMEOUT_CYCLES=N: abort after N ACCESS cycles with PREADY low. rsp_valid follows one cycle later. PSELx/PENABLE drop in the abort cycle+1.
- rsp_* outputs are valid only while rsp_valid=1. They hold their values until the next completion.
- Async reset mid-transfer: PSELx/PENABLE/rsp_valid drop immediately, no response is issued, and the FSM restarts in IDLE.

## Structure
- shared_pkg: ADDR_WIDTH, DATA_WIDTH, UART register address constants (TX data 16'h4000, RX data 16'h4008), apb_state_e enum {IDLE, SETUP, ACCESS}.
- Single module; no sub-module. Timeout counter and FSM are inline.

## Test plan
- Write 32'hDEADBEEF to 16'h4000, strb 4'b1111, PREADY tied 1.
  - SETUP at T+1, ACCESS at T+2.
  - rsp_valid at T+3, rsp_err=0.
- Read 16'h4008 with 3 PREADY-low cycles, slave PRDATA=32'h000000EF.
  - PSTRB=0 throughout.
  - rsp_valid at T+6, rsp_rdata=32'h000000EF.
- Write to 16'h4001, slave asserts PSLVERR with PREADY.
  - rsp_err=1, rsp_timeout=0.
- PREADY held 0, TIMEOUT_CYCLES=16.
  - Abort after 16 ACCESS cycles.
  - rsp_err=rsp_timeout=1, rsp_rdata=0, then IDLE.
- req_valid held for three writes (32'hDEADBEEF, 32'hAAAAAAAA, 32'hDEADBE1D with strb 4'b1110) at zero wait.
  - Handshakes at T, T+3, T+6.
  - PSTRB=4'b1110 on the third transfer.
- PRESETn pulsed low during ACCESS.
  - All outputs 0 asynchronously, no rsp_valid.
  - A new request is accepted the first cycle after release.
